window_fetcher: RTL and testbench

WINDOW_FETCHER -- requirements
Module: window_fetcher

---
 rtl/window_fetcher_pkg.sv | 24 ++
 rtl/window_addr_gen.sv | 31 +++
 rtl/window_fetcher.sv | 148 ++++++++++++++
 tb/tb_window_fetcher.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/window_fetcher_pkg.sv
// Shared types and sizing helpers for the window fetcher: FSM state encoding,
// default map dimensions and padded-image geometry.
package window_fetcher_pkg;

  localparam int DEF_INPUT_WIDTH  = 8;
  localparam int DEF_INPUT_HEIGHT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } fetch_state_e;

  // Padded image edge: output map edge plus the kernel overhang.
  function automatic int padded_dim(input int dim, input int kernel);
    return dim + kernel - 1;
  endfunction

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Combinational read-address generator: maps the latched window origin plus the
// row/column counters onto the row-major padded image.
module window_addr_gen #(
  parameter int ADDR_W   = 7,
  parameter int PADDED_W = 10,
  parameter int H_W      = 3,
  parameter int W_W      = 3,
  parameter int RC_W     = 2
) (
  input  logic              rd_en_i,
  input  logic [H_W-1:0]    h_base_i,
  input  logic [W_W-1:0]    w_base_i,
  input  logic [RC_W-1:0]   row_i,
  input  logic [RC_W-1:0]   col_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] abs_row;
  logic [ADDR_W-1:0] abs_col;

  // Widen every operand before adding so the largest window origin cannot wrap.
  always_comb begin
    abs_row = ADDR_W'(h_base_i) + ADDR_W'(row_i);
    abs_col = ADDR_W'(w_base_i) + ADDR_W'(col_i);
    addr_o  = '0;
    if (rd_en_i) begin
      addr_o = abs_row * ADDR_W'(PADDED_W) + abs_col;
    end
  end

endmodule

// File: rtl/window_fetcher.sv
// Fetches a KERNEL_SIZE x KERNEL_SIZE pixel window from a pre-padded row-major
// image memory with one-cycle read latency and presents it as a flat vector.
module window_fetcher
  import window_fetcher_pkg::*;
#(
  parameter int KERNEL_SIZE  = 3,
  parameter int PIXEL_WIDTH  = 8,
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int INPUT_HEIGHT = DEF_INPUT_HEIGHT,
  localparam int PADDED_W    = padded_dim(INPUT_WIDTH, KERNEL_SIZE),
  localparam int PADDED_H    = padded_dim(INPUT_HEIGHT, KERNEL_SIZE),
  localparam int ADDR_W      = $clog2(PADDED_W * PADDED_H),
  localparam int W_LOG       = clog2_min1(INPUT_WIDTH),
  localparam int H_LOG       = clog2_min1(INPUT_HEIGHT)
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       input_req,
  input  logic [W_LOG-1:0]                           width_index,
  input  logic [H_LOG-1:0]                           height_index,
  output logic                                       input_ready,
  output logic                                       busy,
  output logic                                       mem_rd_en,
  output logic [ADDR_W-1:0]                          mem_addr,
  input  logic [PIXEL_WIDTH-1:0]                     mem_rdata,
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_WIDTH-1:0] window
);

  localparam int NUM_PIX = KERNEL_SIZE * KERNEL_SIZE;
  localparam int K_W     = clog2_min1(NUM_PIX);
  localparam int RC_W    = clog2_min1(KERNEL_SIZE);

  fetch_state_e     state_q, state_d;
  logic [H_LOG-1:0] h_base_q, h_base_d;
  logic [W_LOG-1:0] w_base_q, w_base_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [RC_W-1:0]  row_q, row_d;
  logic [RC_W-1:0]  col_q, col_d;
  logic [K_W-1:0]   k_dly_q;
  logic             rd_en_dly_q;

  always_comb begin
    state_d     = state_q;
    h_base_d    = h_base_q;
    w_base_d    = w_base_q;
    k_d         = k_q;
    row_d       = row_q;
    col_d       = col_q;
    mem_rd_en   = 1'b0;
    input_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (input_req) begin
          h_base_d = height_index;
          w_base_d = width_index;
          k_d      = '0;
          row_d    = '0;
          col_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd_en = 1'b1;
        k_d       = k_q + K_W'(1);
        // Row/column counters track k so the address needs no divide by K.
        if (col_q == RC_W'(KERNEL_SIZE - 1)) begin
          col_d = '0;
          row_d = row_q + RC_W'(1);
        end else begin
          col_d = col_q + RC_W'(1);
        end
        if (k_q == K_W'(NUM_PIX - 1)) begin
          k_d     = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = READY;
      end
      READY: begin
        // A withdrawn request silently discards the finished window.
        input_ready = input_req;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      h_base_q    <= '0;
      w_base_q    <= '0;
      k_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      k_dly_q     <= '0;
      rd_en_dly_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_base_q    <= h_base_d;
      w_base_q    <= w_base_d;
      k_q         <= k_d;
      row_q       <= row_d;
      col_q       <= col_d;
      k_dly_q     <= k_q;
      rd_en_dly_q <= mem_rd_en;
    end
  end

  assign busy = (state_q != IDLE);

  window_addr_gen #(
    .ADDR_W   (ADDR_W),
    .PADDED_W (PADDED_W),
    .H_W      (H_LOG),
    .W_W      (W_LOG),
    .RC_W     (RC_W)
  ) u_addr_gen (
    .rd_en_i  (mem_rd_en),
    .h_base_i (h_base_q),
    .w_base_i (w_base_q),
    .row_i    (row_q),
    .col_i    (col_q),
    .addr_o   (mem_addr)
  );

  // One register per window slot, written when its read returns.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIX; gi++) begin : g_slot
      logic [PIXEL_WIDTH-1:0] pix_q;
      always_ff @(posedge clock) begin
        if (reset) begin
          pix_q <= '0;
        end else if (rd_en_dly_q && (k_dly_q == K_W'(gi))) begin
          pix_q <= mem_rdata;
        end
      end
      assign window[gi*PIXEL_WIDTH +: PIXEL_WIDTH] = pix_q;
    end
  endgenerate

endmodule

// File: tb/tb_window_fetcher.sv
// Randomized self-checking bench for window_fetcher: a one-cycle-latency memory
// model plus an arithmetic reference for addresses, timing and window contents.
module tb_window_fetcher;

  localparam int K    = 3;
  localparam int PW   = 8;
  localparam int PADW = 10;
  localparam int NP   = K * K;
  localparam int AW   = 7;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           input_req = 1'b0;
  logic [2:0]     width_index = '0;
  logic [2:0]     height_index = '0;
  logic           input_ready;
  logic           busy;
  logic           mem_rd_en;
  logic [AW-1:0]  mem_addr;
  logic [PW-1:0]  mem_rdata;
  logic [NP*PW-1:0] window;

  logic [7:0]     mem [100];
  logic [NP*PW-1:0] model_win = '0;
  int checks   = 0;
  int failures = 0;

  window_fetcher dut (
    .clock        (clock),
    .reset        (reset),
    .input_req    (input_req),
    .width_index  (width_index),
    .height_index (height_index),
    .input_ready  (input_ready),
    .busy         (busy),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .window       (window)
  );

  always #5 clock = ~clock;

  // Read data appears one cycle after the strobe; otherwise the bus carries junk.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    else           mem_rdata <= 8'($urandom);
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_addr(input int h, input int w, input int k);
    return (h + k / K) * PADW + (w + k % K);
  endfunction

  function automatic logic [NP*PW-1:0] ref_window(input int h, input int w);
    logic [NP*PW-1:0] win;
    win = '0;
    for (int k = 0; k < NP; k++) win[k*PW +: PW] = mem[ref_addr(h, w, k)];
    return win;
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_rden"}, mem_rd_en, 1'b0);
    check_val({tag, "_addr"}, mem_addr, '0);
    check_val({tag, "_ready"}, input_ready, 1'b0);
  endtask

  // One controller transaction. drop/chg/rst give the cycle (1..10) at which the
  // request is withdrawn, indices are scrambled, or reset is pulsed; 0 = never.
  task automatic do_fetch(input int h, input int w, input int drop_cyc,
                          input int chg_cyc, input int rst_cyc, input int gap);
    bit req_held = 1'b1;
    bit aborted  = 1'b0;
    int exp_a;
    height_index = 3'(h);
    width_index  = 3'(w);
    input_req    = 1'b1;
    for (int j = 1; j <= 12 && !aborted; j++) begin
      @(posedge clock); @(negedge clock);
      if (rst_cyc != 0 && j == rst_cyc + 1) begin
        check_idle("rst");
        check_val("rst_window", window, '0);
        reset = 1'b0;
        input_req = 1'b0;
        model_win = '0;
        @(posedge clock); @(negedge clock);
        check_val("rst_stale_data", window, '0);
        check_val("rst_busy2", busy, 1'b0);
        aborted = 1'b1;
      end else begin
        exp_a = (j <= NP) ? ref_addr(h, w, j - 1) : 0;
        check_val("busy", busy, (j <= 11) ? 1'b1 : 1'b0);
        check_val("rd_en", mem_rd_en, (j <= NP) ? 1'b1 : 1'b0);
        check_val("addr", mem_addr, exp_a);
        check_val("ready", input_ready, (j == 11 && req_held) ? 1'b1 : 1'b0);
        if (j <= 2) check_val("win_hold", window, model_win);
        if (j == 11) begin
          model_win = ref_window(h, w);
          check_val("window", window, model_win);
        end
        if (j == 12) check_val("win_after", window, model_win);
        if (j == chg_cyc) begin
          height_index = 3'($urandom);
          width_index  = 3'($urandom);
        end
        if (j == drop_cyc) begin
          input_req = 1'b0;
          req_held  = 1'b0;
        end
        if (j == rst_cyc) reset = 1'b1;
        if (j == 11) input_req = 1'b0;
      end
    end
    $display("fetch h=%0d w=%0d drop=%0d chg=%0d rst=%0d checks=%0d failures=%0d",
             h, w, drop_cyc, chg_cyc, rst_cyc, checks, failures);
    for (int g = 0; g < gap; g++) begin
      @(posedge clock); @(negedge clock);
      check_idle("gap");
      check_val("gap_window", window, model_win);
    end
  endtask

  initial begin
    for (int a = 0; a < 100; a++) mem[a] = 8'(a);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    check_val("reset_window", window, '0);
    reset = 1'b0;
    @(posedge clock); @(negedge clock);
    check_idle("idle_noreq");

    do_fetch(2, 3, 0, 0, 0, 3);   // nominal window
    do_fetch(7, 7, 0, 0, 0, 3);   // last window, largest addresses
    do_fetch(5, 1, 0, 3, 0, 3);   // indices scrambled mid-fetch
    do_fetch(4, 4, 5, 0, 0, 2);   // request withdrawn at cycle 5
    do_fetch(1, 6, 0, 0, 4, 0);   // reset during ISSUE
    do_fetch(0, 0, 0, 0, 0, 3);   // fresh fetch after reset
    do_fetch(6, 2, 0, 0, 0, 3);   // back-to-back controller loop

    for (int a = 0; a < 100; a++) mem[a] = 8'($urandom);
    for (int n = 0; n < 40; n++) begin
      int drop, chg, rst;
      drop = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 10)) : 0;
      chg  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : 0;
      rst  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 10)) : 0;
      do_fetch(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               drop, chg, rst, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
